qif_neuron_array: RTL and testbench

Time-multiplexed array of N_CH quadratic integrate-and-fire neurons sharing one QIF datapath.
- Membrane potentials and input currents live in internal register files.
- Each `step` pulse advances every channel by one discrete time step, sweeping one channel per cycle.
- Parametrised successor of the single-neuron QIF tile; sits behind the tile's IO wrapper, which drives current writes, steps and readback.

---
 rtl/qif_pkg.sv | 34 +++
 rtl/qif_update_core.sv | 39 +++
 rtl/qif_neuron_array.sv | 188 ++++++++++++++++++
 tb/tb_qif_neuron_array.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qif_pkg.sv
// Shared types, FSM encoding and saturation helper for the QIF neuron array.
package qif_pkg;

    localparam int QIF_W = 16;

    typedef logic signed [QIF_W-1:0] vmem_t;

    localparam vmem_t VMEM_MAX = vmem_t'((2 ** (QIF_W - 1)) - 1);
    localparam vmem_t VMEM_MIN = vmem_t'(-(2 ** (QIF_W - 1)));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Clamp a wide signed value to the range of a w-bit signed word.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] x,
                                                 input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        res = x;
        if (x > hi) begin
            res = hi;
        end else if (x < lo) begin
            res = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/qif_update_core.sv
// Stage-2 combinational QIF update: v' = v + (v*v >> SHIFT) + I, with spike/reset and saturation.
module qif_update_core
    import qif_pkg::*;
#(
    parameter int W       = QIF_W,
    parameter int SHIFT   = 8,
    parameter int V_PEAK  = 1024,
    parameter int V_RESET = -256
) (
    input  logic signed [W-1:0] v,
    input  logic signed [W-1:0] i_cur,
    input  logic                refr_act,
    output logic signed [W-1:0] v_next,
    output logic                spike
);

    localparam int SW = 2 * W + 2;
    localparam logic signed [SW-1:0] PEAK_EXT = SW'(V_PEAK);
    localparam logic signed [W-1:0]  RESET_V  = W'(V_RESET);

    function automatic logic signed [W-1:0] sat_v(input logic signed [SW-1:0] x);
        return W'(sat_w(64'(x), W));
    endfunction

    logic signed [2*W-1:0] prod;
    logic        [2*W-1:0] sq;
    logic signed [SW-1:0]  sum;
    logic                  over;

    always_comb begin
        prod   = (2 * W)'(v) * (2 * W)'(v);
        sq     = $unsigned(prod) >> SHIFT;
        sum    = SW'(v) + SW'($signed({1'b0, sq})) + SW'(i_cur);
        over   = (sum >= PEAK_EXT);
        spike  = !refr_act && over;
        v_next = (refr_act || over) ? RESET_V : sat_v(sum);
    end

endmodule

// File: rtl/qif_neuron_array.sv
// Time-multiplexed array of N_CH QIF neurons sharing one two-stage datapath.
// Optional refractory counters are enabled by defining QIF_REFRACTORY_EN.
module qif_neuron_array
    import qif_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int W       = 16,
    parameter int SHIFT   = 8,
    parameter int V_PEAK  = 1024,
    parameter int V_RESET = -256,
    parameter int REFRACT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cur_we,
    input  logic [$clog2(N_CH)-1:0] cur_addr,
    input  logic signed [W-1:0]     cur_data,
    input  logic                    step,
    output logic                    busy,
    output logic                    done,
    output logic [N_CH-1:0]         spike_out,
    input  logic [$clog2(N_CH)-1:0] vmem_sel,
    output logic signed [W-1:0]     vmem_rd
);

    localparam int AW = $clog2(N_CH);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_CH - 1);

    state_e              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic signed [W-1:0] vmem_q [N_CH];
    logic signed [W-1:0] vmem_d [N_CH];
    logic signed [W-1:0] cur_q  [N_CH];
    logic signed [W-1:0] cur_d  [N_CH];
    logic [N_CH-1:0]     spk_acc_q, spk_acc_d;
    logic [N_CH-1:0]     spike_out_q, spike_out_d;
    logic                done_q, done_d;
    logic                vld_p1_q, vld_p1_d;

    logic [AW-1:0]       idx_p1_q, idx_p1_d;
    logic signed [W-1:0] v_p1_q, v_p1_d;
    logic signed [W-1:0] i_p1_q, i_p1_d;
    logic                refr_p1_q, refr_p1_d;

    logic                refr_rd;
    logic signed [W-1:0] v_next;
    logic                spike_nx;

    // Stage 2: update of the channel captured last cycle
    qif_update_core #(
        .W       (W),
        .SHIFT   (SHIFT),
        .V_PEAK  (V_PEAK),
        .V_RESET (V_RESET)
    ) u_core (
        .v        (v_p1_q),
        .i_cur    (i_p1_q),
        .refr_act (refr_p1_q),
        .v_next   (v_next),
        .spike    (spike_nx)
    );

`ifdef QIF_REFRACTORY_EN
    localparam int CW = $clog2(REFRACT + 1);

    logic [CW-1:0] refr_q [N_CH];
    logic [CW-1:0] refr_d [N_CH];

    assign refr_rd = (refr_q[idx_q] != '0);

    always_comb begin
        refr_d = refr_q;
        if (vld_p1_q) begin
            if (refr_p1_q) begin
                refr_d[idx_p1_q] = refr_q[idx_p1_q] - CW'(1);
            end else if (spike_nx) begin
                refr_d[idx_p1_q] = CW'(REFRACT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                refr_q[c] <= '0;
            end
        end else begin
            refr_q <= refr_d;
        end
    end
`else
    logic refract_unused;
    assign refract_unused = (REFRACT != 0);
    assign refr_rd        = 1'b0;
`endif

    // Stage 1: register-file read of the issued channel
    always_comb begin
        idx_p1_d  = idx_q;
        v_p1_d    = vmem_q[idx_q];
        i_p1_d    = cur_q[idx_q];
        refr_p1_d = refr_rd;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vld_p1_d    = 1'b0;
        spk_acc_d   = spk_acc_q;
        spike_out_d = spike_out_q;
        done_d      = 1'b0;
        vmem_d      = vmem_q;
        cur_d       = cur_q;

        if (cur_we) begin
            cur_d[cur_addr] = cur_data;
        end

        if (vld_p1_q) begin
            vmem_d[idx_p1_q]    = v_next;
            spk_acc_d[idx_p1_q] = spike_nx;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (step) begin
                    state_d   = ST_SWEEP;
                    idx_d     = '0;
                    spk_acc_d = '0;
                end
            end
            ST_SWEEP: begin
                vld_p1_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_FLUSH;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            ST_FLUSH: begin
                // Last channel's spike bit is merged in the same cycle it is written back
                state_d     = ST_IDLE;
                done_d      = 1'b1;
                spike_out_d = spk_acc_d;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            vld_p1_q    <= 1'b0;
            spk_acc_q   <= '0;
            spike_out_q <= '0;
            done_q      <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                vmem_q[c] <= '0;
                cur_q[c]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vld_p1_q    <= vld_p1_d;
            spk_acc_q   <= spk_acc_d;
            spike_out_q <= spike_out_d;
            done_q      <= done_d;
            vmem_q      <= vmem_d;
            cur_q       <= cur_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_p1_q  <= idx_p1_d;
        v_p1_q    <= v_p1_d;
        i_p1_q    <= i_p1_d;
        refr_p1_q <= refr_p1_d;
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign spike_out = spike_out_q;
    assign vmem_rd   = vmem_q[vmem_sel];

endmodule

// File: tb/tb_qif_neuron_array.sv
// Directed and randomized bench for qif_neuron_array against a per-step arithmetic model.
`timescale 1ns/1ps
module tb_qif_neuron_array;

    localparam int N_CH    = 4;
    localparam int W       = 16;
    localparam int AW      = 2;
    localparam int SHIFT   = 8;
    localparam int V_PEAK  = 1024;
    localparam int V_RESET = -256;
    localparam int REFRACT = 2;
`ifdef QIF_REFRACTORY_EN
    localparam bit REFR_EN = 1'b1;
`else
    localparam bit REFR_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                cur_we;
    logic [AW-1:0]       cur_addr;
    logic signed [W-1:0] cur_data;
    logic                step;
    logic                busy;
    logic                done;
    logic [N_CH-1:0]     spike_out;
    logic [AW-1:0]       vmem_sel;
    logic signed [W-1:0] vmem_rd;

    qif_neuron_array #(
        .N_CH    (N_CH),
        .W       (W),
        .SHIFT   (SHIFT),
        .V_PEAK  (V_PEAK),
        .V_RESET (V_RESET),
        .REFRACT (REFRACT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cur_we    (cur_we),
        .cur_addr  (cur_addr),
        .cur_data  (cur_data),
        .step      (step),
        .busy      (busy),
        .done      (done),
        .spike_out (spike_out),
        .vmem_sel  (vmem_sel),
        .vmem_rd   (vmem_rd)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    longint          m_v [N_CH];
    longint          m_i [N_CH];
    int              m_r [N_CH];
    logic [N_CH-1:0] m_spk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_v[c] = 0;
            m_i[c] = 0;
            m_r[c] = 0;
        end
        m_spk = '0;
    endtask

    task automatic model_step();
        longint sq;
        longint sum;
        for (int c = 0; c < N_CH; c++) begin
            m_spk[c] = 1'b0;
            if (m_r[c] > 0) begin
                m_r[c]--;
                m_v[c] = V_RESET;
            end else begin
                sq  = (m_v[c] * m_v[c]) / (64'sd1 <<< SHIFT);
                sum = m_v[c] + sq + m_i[c];
                if (sum >= V_PEAK) begin
                    m_spk[c] = 1'b1;
                    m_v[c]   = V_RESET;
                    if (REFR_EN) m_r[c] = REFRACT;
                end else if (sum > 32767) begin
                    m_v[c] = 32767;
                end else if (sum < -32768) begin
                    m_v[c] = -32768;
                end else begin
                    m_v[c] = sum;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_cur(input int addr, input int data);
        cur_we   = 1'b1;
        cur_addr = AW'(addr);
        cur_data = W'(data);
        @(posedge clk); #1;
        cur_we = 1'b0;
        m_i[addr] = data;
    endtask

    task automatic read_v(input int ch, output logic signed [31:0] val);
        vmem_sel = AW'(ch);
        #1;
        val = vmem_rd;
    endtask

    task automatic compare_all(input string tag);
        logic signed [31:0] val;
        for (int c = 0; c < N_CH; c++) begin
            read_v(c, val);
            check($sformatf("%s.v%0d", tag, c), val, 32'(m_v[c]));
        end
        check($sformatf("%s.spike_out", tag), 32'(spike_out), 32'(m_spk));
    endtask

    // One step pulse; optional step re-pokes while busy and one current write during sweep cycle wr_cyc.
    task automatic run_step(input string tag, input bit poke, input int wr_cyc,
                            input int wr_addr, input int wr_data);
        int lat = -1;
        int n_done = 0;
        logic busy_at_done = 1'b1;
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        check($sformatf("%s.busy_t1", tag), 32'(busy), 1);
        for (int k = 1; k <= 10; k++) begin
            if (poke && k <= 3) step = 1'b1;
            if (k == wr_cyc) begin
                cur_we   = 1'b1;
                cur_addr = AW'(wr_addr);
                cur_data = W'(wr_data);
            end
            @(posedge clk); #1;
            step   = 1'b0;
            cur_we = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (lat < 0) begin
                    lat = k + 1;
                    busy_at_done = busy;
                end
            end
        end
        check($sformatf("%s.done_latency", tag), lat, 6);
        check($sformatf("%s.done_count", tag), n_done, 1);
        check($sformatf("%s.busy_at_done", tag), 32'(busy_at_done), 0);
        model_step();
        if (wr_cyc > 0) m_i[wr_addr] = wr_data;
        compare_all(tag);
    endtask

    initial begin
        logic signed [31:0] val;
        logic signed [15:0] r16;
        int g_exp [4];
        int r_exp [3];
        int n_done;

        rst      = 1'b1;
        cur_we   = 1'b0;
        cur_addr = '0;
        cur_data = '0;
        step     = 1'b0;
        vmem_sel = '0;

        do_reset();
        check("reset.busy", 32'(busy), 0);
        check("reset.done", 32'(done), 0);
        check("reset.spike_out", 32'(spike_out), 0);
        compare_all("reset");

        run_step("zero_step", 1'b0, 0, 0, 0);

        g_exp = '{100, 239, 562, -256};
        write_cur(0, 100);
        for (int s = 0; s < 4; s++) begin
            run_step($sformatf("grow%0d", s), 1'b0, 0, 0, 0);
            read_v(0, val);
            check($sformatf("grow%0d.v0_lit", s), val, g_exp[s]);
            check($sformatf("grow%0d.spk0_lit", s), 32'(spike_out[0]), (s == 3) ? 1 : 0);
        end

`ifdef QIF_REFRACTORY_EN
        r_exp = '{-256, -256, 100};
`else
        r_exp = '{100, 239, 562};
`endif
        for (int s = 0; s < 3; s++) begin
            run_step($sformatf("post%0d", s), 1'b0, 0, 0, 0);
            read_v(0, val);
            check($sformatf("post%0d.v0_lit", s), val, r_exp[s]);
            check($sformatf("post%0d.spk0_lit", s), 32'(spike_out[0]), 0);
        end

        write_cur(1, -100);
        run_step("sat_a", 1'b0, 0, 0, 0);
        read_v(1, val);
        check("sat_a.v1_lit", val, -100);
        write_cur(1, -32768);
        run_step("sat_b", 1'b0, 0, 0, 0);
        read_v(1, val);
        check("sat_b.v1_lit", val, -32768);
        check("sat_b.spk1_lit", 32'(spike_out[1]), 0);

        run_step("poke", 1'b1, 0, 0, 0);

        do_reset();
        run_step("rbw_a", 1'b0, 3, 2, 50);
        read_v(2, val);
        check("rbw_a.v2_lit", val, 0);
        run_step("rbw_b", 1'b0, 0, 0, 0);
        read_v(2, val);
        check("rbw_b.v2_lit", val, 50);

        for (int it = 0; it < 20; it++) begin
            int nw;
            nw = int'($urandom_range(0, 2));
            for (int w = 0; w < nw; w++) begin
                int d;
                if ($urandom_range(0, 9) == 0) begin
                    r16 = 16'($urandom);
                    d   = int'(r16);
                end else begin
                    d = int'($urandom_range(0, 800)) - 400;
                end
                write_cur(int'($urandom_range(0, N_CH - 1)), d);
            end
            run_step($sformatf("rand%0d", it), 1'($urandom_range(0, 1)), 0, 0, 0);
        end

        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("abort.busy", 32'(busy), 0);
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        check("abort.done_count", n_done, 0);
        compare_all("abort");
        run_step("abort_step", 1'b0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
